// File: rtl/audio_pkg.sv
// Shared constants, state encoding and helpers for the audio playback sequencer.
package audio_pkg;

  localparam int unsigned SampleW = 16;
  localparam int unsigned SpeedW  = 4;
  // Interpolation arithmetic needs one extra bit to hold cur - prev without wrapping.
  localparam int unsigned DeltaW  = SampleW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCalc,
    StWait
  } seq_state_t;

  // Out-of-range slow-down factors (0, 9..15) fall back to real-time playback.
  function automatic logic [SpeedW-1:0] sanitize_speed(input logic [SpeedW-1:0] s);
    return ((s == '0) || (s > SpeedW'(8))) ? SpeedW'(1) : s;
  endfunction

  // Clamp a widened accumulator back into the 16-bit signed sample range.
  function automatic logic signed [SampleW-1:0] sat16(input logic signed [DeltaW-1:0] v);
    if (v > DeltaW'(32767)) begin
      return 16'sh7fff;
    end else if (v < -DeltaW'(32768)) begin
      return 16'sh8000;
    end else begin
      return v[SampleW-1:0];
    end
  endfunction

endpackage

// File: rtl/audio_interp_step.sv
// Combinational per-output step: (cur - prev) / N via shift-add on the magnitude.
module audio_interp_step
  import audio_pkg::*;
(
  input  logic signed [SampleW-1:0] cur,
  input  logic signed [SampleW-1:0] prev,
  input  logic        [SpeedW-1:0]  speed,
  output logic signed [DeltaW-1:0]  q
);

  logic signed [DeltaW-1:0] delta;
  logic        [DeltaW-1:0] mag;
  logic        [DeltaW-1:0] quot;

  // Divide the magnitude so each shifted term truncates toward zero, then reapply the sign.
  always_comb begin
    delta = DeltaW'(cur) - DeltaW'(prev);
    mag   = delta[DeltaW-1] ? DeltaW'(-delta) : DeltaW'(delta);
    case (speed)
      4'd2:    quot = mag >> 1;
      4'd3:    quot = (mag >> 2) + (mag >> 4) + (mag >> 6);
      4'd4:    quot = mag >> 2;
      4'd5:    quot = (mag >> 3) + (mag >> 4) + (mag >> 6);
      4'd6:    quot = (mag >> 3) + (mag >> 5) + (mag >> 7);
      4'd7:    quot = (mag >> 3) + (mag >> 6) + (mag >> 9);
      4'd8:    quot = mag >> 3;
      default: quot = mag;
    endcase
    q = delta[DeltaW-1] ? -$signed(quot) : $signed(quot);
  end

endmodule

// File: rtl/audio_playback_sequencer.sv
// Fetches samples from the source and emits N held or interpolated outputs per sample.
module audio_playback_sequencer
  import audio_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic        [SpeedW-1:0]  i_speed,
  input  logic                      i_interp,
  input  logic                      i_sample_req,
  output logic                      o_src_req,
  input  logic                      i_src_valid,
  input  logic signed [SampleW-1:0] i_src_data,
  input  logic                      i_src_last,
  output logic signed [SampleW-1:0] o_sample,
  output logic                      o_sample_valid,
  output logic                      o_underrun,
  output logic                      o_busy,
  output logic                      o_done
);

  seq_state_t               state;
  logic        [SpeedW-1:0] speed_n;
  logic                     interp_mode;
  logic signed [SampleW-1:0] prev;
  logic signed [SampleW-1:0] cur;
  logic signed [DeltaW-1:0] acc;
  logic signed [DeltaW-1:0] q;
  logic signed [DeltaW-1:0] q_next;
  logic        [SpeedW-1:0] step;
  logic                     last_seg;
  logic                     pending;
  logic                     xfer;
  logic                     emit;
  logic                     seg_end;

  audio_interp_step u_interp_step (
    .cur   (cur),
    .prev  (prev),
    .speed (speed_n),
    .q     (q_next)
  );

  assign o_src_req = (state == StFetch);
  assign o_busy    = (state != StIdle);
  assign xfer      = o_src_req & i_src_valid;
  // A buffered request counts as a live one on the first WAIT cycle.
  assign emit      = (state == StWait) & (i_sample_req | pending);
  assign seg_end   = (step == (speed_n - SpeedW'(1)));

  // Sequencer FSM with registered sample path and strobes; stop overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= StIdle;
      speed_n        <= SpeedW'(1);
      interp_mode    <= 1'b0;
      prev           <= '0;
      cur            <= '0;
      acc            <= '0;
      q              <= '0;
      step           <= '0;
      last_seg       <= 1'b0;
      pending        <= 1'b0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_underrun     <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      o_underrun     <= 1'b0;
      o_done         <= 1'b0;
      if (i_stop) begin
        state   <= StIdle;
        pending <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (i_start) begin
              speed_n     <= sanitize_speed(i_speed);
              interp_mode <= i_interp;
              prev        <= '0;
              cur         <= '0;
              step        <= '0;
              pending     <= 1'b0;
              state       <= StFetch;
            end
          end
          StFetch, StCalc: begin
            if (i_sample_req) begin
              if (pending) o_underrun <= 1'b1;
              else         pending    <= 1'b1;
            end
            if (state == StFetch) begin
              if (xfer) begin
                prev     <= cur;
                cur      <= i_src_data;
                step     <= '0;
                last_seg <= i_src_last;
                state    <= StCalc;
              end
            end else begin
              q     <= q_next;
              acc   <= DeltaW'(prev);
              state <= StWait;
            end
          end
          StWait: begin
            if (emit) begin
              o_sample       <= interp_mode ? sat16(acc) : prev;
              o_sample_valid <= 1'b1;
              acc            <= acc + q;
              step           <= step + SpeedW'(1);
              // With a buffered request outstanding, a fresh one takes its place.
              pending        <= pending & i_sample_req;
              if (seg_end) begin
                if (last_seg) begin
                  state   <= StIdle;
                  o_done  <= 1'b1;
                  pending <= 1'b0;
                end else begin
                  state <= StFetch;
                end
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
